ex_seq_multiplier: RTL

- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops in the EX stage.
- Sits beside the ALU and is fed from the ID/EX register. Its result returns to the EX result mux.
- Each step adds with the team's ripple-carry adder datapath (full_adder chain), one partial product per cycle.
- A valid/ready handshake on both sides lets the hazard unit stall the pipeline while it is busy.

---
 rtl/ex_pkg.sv | 23 ++
 rtl/full_adder.sv | 15 +
 rtl/mul_step_adder.sv | 31 +++
 rtl/ex_seq_multiplier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: multiplier op encodings, multiplier FSM
// states and the default datapath width.
package ex_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // RV32M multiply ops as presented on the 2-bit op port
    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    // Sequential multiplier control states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple-carry chains.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mul_step_adder.sv
// W-bit ripple-carry adder made of full_adder cells.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : W-bit sum
//   cout : carry out of bit W-1
module mul_step_adder #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/ex_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operates on operand magnitudes, one multiplier bit per cycle, and applies
// the sign fix-up over the full 2*XLEN product in a single FIX cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (ready only when idle)
//   op, rs1, rs2         : operation and operands, sampled at accept
//   out_valid / out_ready: result handshake (valid only in DONE)
//   result               : selected product half, held until taken
//   busy                 : operation in flight or result pending
// Build option MUL_EARLY_EXIT_EN: leave CALC as soon as the remaining
// multiplier bits are zero, finishing the shift with a barrel shifter.
module ex_seq_multiplier
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN + 1);

    mul_state_e      state_q, state_d;
    mul_op_e         op_q, op_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] result_d;

    // Operand conditioning at accept: magnitudes and product sign
    mul_op_e         op_in;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;

    assign op_in   = mul_op_e'(op);
    assign rs1_neg = ((op_in == MUL_OP_MULH) || (op_in == MUL_OP_MULHSU)) && rs1[XLEN-1];
    assign rs2_neg = (op_in == MUL_OP_MULH) && rs2[XLEN-1];
    assign rs1_mag = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    assign rs2_mag = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;

    // Shared adder: partial-product add in CALC, low-half negate in FIX
    logic [XLEN:0]   add_a, add_b, add_sum;
    logic            add_cin, add_cout;
    logic [XLEN-1:0] hi_sum;
    logic            hi_cout;
    logic            unused_cout;

    always_comb begin
        add_a   = {1'b0, acc_q[AW-1:XLEN]};
        add_b   = mplier_q[0] ? {1'b0, mcand_q} : '0;
        add_cin = 1'b0;
        if (state_q == S_FIX) begin
            add_a   = {1'b0, ~acc_q[XLEN-1:0]};
            add_b   = '0;
            add_cin = 1'b1;
        end
    end

    mul_step_adder #(.W(XLEN + 1)) u_step_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // High half of the negation takes the low half's carry out of bit XLEN-1
    mul_step_adder #(.W(XLEN)) u_fix_hi_adder (
        .a    (~acc_q[AW-1:XLEN]),
        .b    ('0),
        .cin  (add_sum[XLEN]),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    assign unused_cout = add_cout ^ hi_cout;

    // Datapath values for the CALC and FIX steps
    logic [AW-1:0] step_acc, calc_acc, fix_acc;
    logic          calc_last;

    assign step_acc = {add_sum, acc_q[XLEN-1:1]};
    assign fix_acc  = neg_q ? {hi_sum, add_sum[XLEN-1:0]} : acc_q;

`ifdef MUL_EARLY_EXIT_EN
    logic          mplier_rest_zero;
    logic [CW-1:0] rem_shift;

    // Remaining zero multiplier bits only shift; do them all at once
    assign mplier_rest_zero = (mplier_q[XLEN-1:1] == '0);
    assign rem_shift        = count_q - CW'(1);
    assign calc_acc         = mplier_rest_zero ? (step_acc >> rem_shift) : step_acc;
    assign calc_last        = mplier_rest_zero || (count_q == CW'(1));
`else
    assign calc_acc  = step_acc;
    assign calc_last = (count_q == CW'(1));
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        count_d  = count_q;
        result_d = result;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d     = op_in;
                    mcand_d  = rs1_mag;
                    mplier_d = rs2_mag;
                    neg_d    = (rs1_neg ^ rs2_neg) && (rs1 != '0) && (rs2 != '0);
                    acc_d    = '0;
                    count_d  = CW'(XLEN);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = calc_acc;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (calc_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                acc_d    = fix_acc;
                result_d = (op_q == MUL_OP_MUL) ? fix_acc[XLEN-1:0] : fix_acc[AW-1:XLEN];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= MUL_OP_MUL;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            count_q   <= count_d;
            result    <= result_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
        end
    end

endmodule
